// File: rtl/etroc2_l1buf_pkg.sv
// Shared constants for the ETROC2 pixel L1 latency buffer.
// Holds the TDC field widths, the stored-record and out_data widths,
// the out_data field offsets and the overflow counter width.
// out_data layout (MSB first): {bcid, hit, err, TOA, TOT, Cal}.
// The stored record is the low REC_W bits of out_data, so the offsets
// below are valid for both.
package etroc2_l1buf_pkg;

  localparam int ADDR_W     = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int TOA_W      = 10;
  localparam int TOT_W      = 9;
  localparam int CAL_W      = 10;
  localparam int OVF_W      = 8;

  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int CODE_W    = TOA_W + TOT_W + CAL_W;
  localparam int REC_W     = 2 + CODE_W;
  localparam int OUT_W     = ADDR_W + REC_W;

  // out_data field offsets
  localparam int CAL_LSB  = 0;
  localparam int TOT_LSB  = CAL_LSB + CAL_W;
  localparam int TOA_LSB  = TOT_LSB + TOT_W;
  localparam int ERR_BIT  = TOA_LSB + TOA_W;
  localparam int HIT_BIT  = ERR_BIT + 1;
  localparam int BCID_LSB = HIT_BIT + 1;

  // Fill counter saturates once every slot of the ring has been written.
  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(MEM_DEPTH);

  // A latency of 0 would address the slot being written this crossing.
  function automatic logic [ADDR_W-1:0] clamp_latency(input logic [ADDR_W-1:0] lat);
    return (lat == '0) ? ADDR_W'(1) : lat;
  endfunction

endpackage

// File: rtl/etroc2_l1buf_fifo.sv
// Synchronous first-word-fall-through FIFO for L1 output records.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   push, push_data - write request and record
//   pop             - consumer accepts the head (ignored while empty)
//   pop_data        - head record, forced to 0 while empty
//   empty           - no record held
//   drop            - push refused because full with no pop this cycle
module etroc2_l1buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] store [DEPTH];
  logic             full, do_push, do_pop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (PTR_W + 1)'(DEPTH));
    do_pop   = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push & (~full | do_pop);
    drop     = push & full & ~do_pop;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    pop_data = empty ? '0 : store[rd_ptr_q];
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; the count and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/etroc2_pixel_l1_buffer.sv
// ETROC2 pixel L1 latency buffer.
// Every 40 MHz crossing one TDC record {hit, err, TOA, TOT, Cal} is written
// into a 2^ADDR_W ring indexed by the free-running BCID. An L1 accept reads
// the record written l1a_latency crossings earlier (one-cycle registered
// read) and pushes {bcid, record} into a small FWFT FIFO drained by
// out_valid/out_ready.
// Ports:
//   clk40, reset                        - clock, synchronous active-high reset
//   enable, hitFlag, errorFlag          - per-crossing TDC flags
//   TOA_code, TOT_code, Cal_code        - TDC codes
//   l1a, l1a_latency                    - L1 accept pulse and latency
//   out_valid, out_ready, out_data      - output record handshake
//   overflow_cnt                        - saturating count of records dropped on full
// Build option: define L1BUF_ZERO_SUPPRESS_EN to drop records with hit=0 and err=0
// instead of pushing them.
module etroc2_pixel_l1_buffer
  import etroc2_l1buf_pkg::*;
(
  input  logic              clk40,
  input  logic              reset,
  input  logic              enable,
  input  logic              hitFlag,
  input  logic [TOA_W-1:0]  TOA_code,
  input  logic [TOT_W-1:0]  TOT_code,
  input  logic [CAL_W-1:0]  Cal_code,
  input  logic              errorFlag,
  input  logic              l1a,
  input  logic [ADDR_W-1:0] l1a_latency,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [OVF_W-1:0]  overflow_cnt
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_mask_q, rd_mask_d;
  logic [ADDR_W-1:0] rd_bcid_q, rd_bcid_d;
  logic [REC_W-1:0]  rd_data_q;
  logic [OVF_W-1:0]  ovf_q, ovf_d;

  logic [REC_W-1:0]  rec_mem [MEM_DEPTH];
  logic [REC_W-1:0]  wr_rec, rd_rec;
  logic [ADDR_W-1:0] eff_lat, rd_addr;
  logic              hit;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_drop;
  logic [OUT_W-1:0]  fifo_push_data;

  always_comb begin
    hit     = hitFlag & enable;
    // Codes are zeroed on empty crossings so a no-hit record is deterministic.
    wr_rec  = hit ? {1'b1, errorFlag, TOA_code, TOT_code, Cal_code}
                  : {1'b0, errorFlag, {CODE_W{1'b0}}};
    eff_lat = clamp_latency(l1a_latency);
    rd_addr = wr_ptr_q - eff_lat;

    wr_ptr_d   = wr_ptr_q + 1'b1;
    fill_d     = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    rd_valid_d = l1a;
    rd_bcid_d  = rd_addr;
    // Slot not written since reset: its contents are stale and must be hidden.
    rd_mask_d  = ({1'b0, eff_lat} > fill_q);

    rd_rec         = rd_mask_q ? '0 : rd_data_q;
    fifo_push_data = {rd_bcid_q, rd_rec};
`ifdef L1BUF_ZERO_SUPPRESS_EN
    fifo_push      = rd_valid_q & (rd_rec[HIT_BIT] | rd_rec[ERR_BIT]);
`else
    fifo_push      = rd_valid_q;
`endif

    fifo_pop = out_valid & out_ready;
    ovf_d    = (fifo_drop && ovf_q != '1) ? ovf_q + 1'b1 : ovf_q;
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_mask_q  <= 1'b0;
      rd_bcid_q  <= '0;
      ovf_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      rd_valid_q <= rd_valid_d;
      rd_mask_q  <= rd_mask_d;
      rd_bcid_q  <= rd_bcid_d;
      ovf_q      <= ovf_d;
    end
  end

  // Ring write and registered read. rd_addr never equals wr_ptr_q because
  // eff_lat is in 1..2^ADDR_W-1, so there is no read/write collision.
  always_ff @(posedge clk40) begin
    rec_mem[wr_ptr_q] <= wr_rec;
    if (l1a) rd_data_q <= rec_mem[rd_addr];
  end

  etroc2_l1buf_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk40),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign out_valid    = ~fifo_empty;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_etroc2_pixel_l1_buffer.sv
module tb_etroc2_pixel_l1_buffer;
  import etroc2_l1buf_pkg::*;

  logic              clk40 = 1'b0;
  logic              reset;
  logic              enable;
  logic              hitFlag;
  logic [TOA_W-1:0]  TOA_code;
  logic [TOT_W-1:0]  TOT_code;
  logic [CAL_W-1:0]  Cal_code;
  logic              errorFlag;
  logic              l1a;
  logic [ADDR_W-1:0] l1a_latency;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [OVF_W-1:0]  overflow_cnt;

  int n_compared   = 0;
  int n_mismatched = 0;
  int bcid         = 0;
  logic [OUT_W-1:0] sb[$];

  etroc2_pixel_l1_buffer dut (
    .clk40        (clk40),
    .reset        (reset),
    .enable       (enable),
    .hitFlag      (hitFlag),
    .TOA_code     (TOA_code),
    .TOT_code     (TOT_code),
    .Cal_code     (Cal_code),
    .errorFlag    (errorFlag),
    .l1a          (l1a),
    .l1a_latency  (l1a_latency),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .overflow_cnt (overflow_cnt)
  );

  always #12 clk40 = ~clk40;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h (bcid %0d)", name, act, exp, bcid);
    end
  endtask

  function automatic logic [OUT_W-1:0] rec(input int b, input bit h, input bit e,
                                           input int toa, input int tot, input int cal);
    return {ADDR_W'(b), h, e, TOA_W'(toa), TOT_W'(tot), CAL_W'(cal)};
  endfunction

  // Monitor: every accepted output record is checked against the scoreboard.
  always @(negedge clk40) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL unexpected_record: got %h, expected none (bcid %0d)", out_data, bcid);
      end else begin
        check("record", 64'(out_data), 64'(sb.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk40);
    #1;
    bcid++;
  endtask

  task automatic run_to(input int target);
    while ((bcid % MEM_DEPTH) != target) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk40);
    #1;
    reset = 1'b0;
    bcid  = 0;
  endtask

  task automatic set_hit(input bit h, input bit e, input int toa, input int tot, input int cal);
    hitFlag   = h;
    errorFlag = e;
    TOA_code  = TOA_W'(toa);
    TOT_code  = TOT_W'(tot);
    Cal_code  = CAL_W'(cal);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; l1a = 1'b0; l1a_latency = '0; out_ready = 1'b1;
    set_hit(0, 0, 0, 0, 0);
    @(posedge clk40); #1;
    do_reset();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_overflow", 64'(overflow_cnt), 64'd0);

    // Basic fetch: latency 100, hit at 37, L1A at 137, valid two cycles later.
    l1a_latency = 9'd100;
    run_to(37);
    set_hit(1, 0, 'h155, 'h0AA, 'h200);
    step();
    set_hit(0, 0, 0, 0, 0);
    run_to(137);
    l1a = 1'b1;
    sb.push_back(rec(37, 1, 0, 'h155, 'h0AA, 'h200));
    step();
    l1a = 1'b0;
    check("latency_t1_valid", 64'(out_valid), 64'd0);
    step();
    check("latency_t2_valid", 64'(out_valid), 64'd1);
    drain("drain_basic");

    // Ring wrap: hit at 500, latency 20, L1A at 8. Max codes, err set.
    l1a_latency = 9'd20;
    run_to(500);
    set_hit(1, 1, 'h3FF, 'h1FF, 'h001);
    step();
    set_hit(0, 0, 0, 0, 0);
    run_to(8);
    l1a = 1'b1;
    sb.push_back(rec(500, 1, 1, 'h3FF, 'h1FF, 'h001));
    step();
    l1a = 1'b0;
    drain("drain_wrap");

    // Overflow: 6 back-to-back L1As into a 4-deep FIFO with the consumer stalled,
    // then a push coinciding with the first pop while full.
    l1a_latency = 9'd10;
    out_ready   = 1'b0;
    run_to(60);
    for (int i = 0; i < 8; i++) begin
      set_hit(1, 0, 'h100 + i, 'h0F0 + i, 'h300 + i);
      step();
    end
    set_hit(0, 0, 0, 0, 0);
    run_to(70);
    for (int i = 0; i < 6; i++) begin
      l1a = 1'b1;
      if (i < 4) sb.push_back(rec(60 + i, 1, 0, 'h100 + i, 'h0F0 + i, 'h300 + i));
      step();
    end
    // bcid 76 reads slot 66; its push lands in the first pop cycle.
    sb.push_back(rec(66, 1, 0, 'h106, 'h0F6, 'h306));
    step();
    l1a = 1'b0;
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_data", 64'(out_data), 64'(rec(60, 1, 0, 'h100, 'h0F0, 'h300)));
    check("overflow_two", 64'(overflow_cnt), 64'd2);
    out_ready = 1'b1;
    drain("drain_overflow");
    check("overflow_after_drain", 64'(overflow_cnt), 64'd2);

    // Stale memory: write a hit at 262, reset, then latency 300 at bcid 50 reads 262.
    run_to(262);
    set_hit(1, 0, 'h2AA, 'h055, 'h0FF);
    step();
    set_hit(0, 0, 0, 0, 0);
    do_reset();
    check("reset_clears_overflow", 64'(overflow_cnt), 64'd0);
    l1a_latency = 9'd300;
    run_to(50);
    l1a = 1'b1;
`ifndef L1BUF_ZERO_SUPPRESS_EN
    sb.push_back(rec(262, 0, 0, 0, 0, 0));
`endif
    step();
    l1a = 1'b0;
    step();
    step();
    check("masked_no_valid_left", 64'(out_valid), 64'd0);
    drain("drain_masked");

    // Latency 0 behaves as latency 1.
    l1a_latency = 9'd0;
    run_to(100);
    set_hit(1, 0, 'h011, 'h022, 'h033);
    step();
    set_hit(0, 0, 0, 0, 0);
    l1a = 1'b1;
    sb.push_back(rec(100, 1, 0, 'h011, 'h022, 'h033));
    step();
    l1a = 1'b0;
    drain("drain_clamp");

    // Reset with 3 records queued and a fourth read in flight.
    l1a_latency = 9'd10;
    out_ready   = 1'b0;
    run_to(200);
    for (int i = 0; i < 4; i++) begin
      set_hit(1, 0, 'h040 + i, 'h050 + i, 'h060 + i);
      step();
    end
    set_hit(0, 0, 0, 0, 0);
    run_to(210);
    l1a = 1'b1;
    step(); step(); step();
    l1a = 1'b0;
    step();
    check("queued_before_reset", 64'(out_valid), 64'd1);
    l1a = 1'b1;
    step();
    l1a = 1'b0;
    do_reset();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_overflow", 64'(overflow_cnt), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();

    // enable=0 suppresses the hit; toggling enable afterwards does not disturb the read.
    run_to(30);
    enable = 1'b0;
    set_hit(1, 0, 'h123, 'h045, 'h067);
    step();
    set_hit(0, 0, 0, 0, 0);
    enable = 1'b1;
    run_to(40);
    l1a = 1'b1;
`ifndef L1BUF_ZERO_SUPPRESS_EN
    sb.push_back(rec(30, 0, 0, 0, 0, 0));
`endif
    step();
    l1a    = 1'b0;
    enable = 1'b0;
    step();
    enable = 1'b1;
`ifdef L1BUF_ZERO_SUPPRESS_EN
    check("suppressed_no_valid", 64'(out_valid), 64'd0);
`else
    check("disabled_valid", 64'(out_valid), 64'd1);
`endif
    drain("drain_enable");

    for (int i = 0; i < 5; i++) step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/etroc2_pixel_l1_buffer.md
Name: etroc2_pixel_l1_buffer

Overview:
Pixel-level L1 latency buffer directly downstream of the pixel TDC. Every clk40 bunch crossing it stores one record: hit flag, TDC error, TOA/TOT/Cal codes. The record goes into a circular buffer indexed by a free-running BCID. On an L1 accept it fetches the record written L1 latency crossings earlier and pushes it into a small output FIFO, which the pixel readout drains via a valid/ready handshake.

Parameters:
ADDR_W, 9, circular buffer address width; depth 2^ADDR_W = 512 crossings
FIFO_DEPTH, 4, output FIFO entries (power of 2)
TOA_W, 10, TOA code width
TOT_W, 9, TOT code width
CAL_W, 10, Cal code width

Ports:
clk40  in  1  40 MHz bunch-crossing clock, sole clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = store incoming hits; 0 = store hit=0 every crossing
hitFlag  in  1  TDC hit for this crossing, aligned with the codes
TOA_code  in  TOA_W  TDC TOA code
TOT_code  in  TOT_W  TDC TOT code
Cal_code  in  CAL_W  TDC Cal code
errorFlag  in  1  OR of TDC TOA/TOT/Cal error flags
l1a  in  1  L1 accept, one-cycle pulse
l1a_latency  in  ADDR_W  L1 latency in crossings; quasi-static
out_valid  out  1  output record available
out_ready  in  1  consumer accepts the record
out_data  out  ADDR_W+2+TOA_W+TOT_W+CAL_W  {bcid, hit, err, TOA, TOT, Cal}, MSB first
overflow_cnt  out  8  L1 records dropped on FIFO full, saturating

Behaviour:
- Reset values: out_valid=0, out_data=0, overflow_cnt=0, bcid/wr_ptr=0, FIFO empty, fill counter=0, read pipeline cleared.
- wr_ptr increments every cycle and wraps from 2^ADDR_W-1 to 0.
- Write every cycle at wr_ptr: {hit=hitFlag&enable, err, TOA, TOT, Cal}. When hit=0, the code fields are written as 0.
- Fill counter counts writes since reset and saturates at 2^ADDR_W.
- L1A in cycle t: rd_addr = (wr_ptr - eff_lat) mod 2^ADDR_W. eff_lat = l1a_latency, except 0 is clamped to 1.
  - Read is registered (1 cycle). The FIFO push happens in t+1. out_valid is asserted no earlier than t+2.
- Pushed record: bcid = rd_addr, plus the stored fields.
  - If eff_lat > fill counter (slot not written since reset), hit, err and codes are forced to 0. Memory is never bulk-cleared.
- L1A on consecutive cycles is legal; each is served in order. Throughput is 1 record/cycle.
- FIFO handshake:
  - A record transfers when out_valid & out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
  - First-word-fall-through; no bubble when the FIFO is not empty.
- FIFO full and push with no pop in the same cycle: record dropped, overflow_cnt += 1, saturating at 255.
- Full with simultaneous push and pop: both occur; no drop.
- Empty with simultaneous push and pop: out_valid is 0 that cycle; the push lands and is valid next cycle.
- Reset mid-operation: FIFO flushed, in-flight read discarded, fill counter cleared. Memory contents are left as-is but masked by the fill rule.
- enable toggling has no effect on pending L1A reads.

Optional Feature:
- Macro L1BUF_ZERO_SUPPRESS_EN.
- Defined: records with hit=0 and err=0 are not pushed and do not count toward overflow.
- Undefined: every L1A pushes exactly one record.

Decomposition:
- Package etroc2_l1buf_pkg holds:
  - field widths
  - record width
  - out_data field offsets (bcid, hit, err, TOA, TOT, Cal)
  - overflow counter width
- One sub-module, etroc2_l1buf_fifo: synchronous FWFT FIFO with push/pop, full/empty, and a drop strobe.
- Circular memory is inferred inline.

Test Plan:
- Latency 100, hit at bcid 37 (TOA=0x155, TOT=0x0AA, Cal=0x200), L1A at bcid 137 -> after 2 cycles out_data={37,1,0,0x155,0x0AA,0x200}, out_valid=1.
- Wrap: hit at bcid 500, latency 20, L1A at bcid 8 -> bcid field 500, codes match.
- 6 consecutive L1As with out_ready=0, depth 4 -> 4 records held, overflow_cnt=2. Drain -> 4 records in order, bcids consecutive.
- Latency 300, L1A at cycle 50 after reset -> record with hit=0, codes 0, despite stale memory from before reset.
- Reset asserted with 3 records queued -> out_valid=0 the next cycle, overflow_cnt=0, no stale record emerges.
- enable=0 with hitFlag=1, then L1A -> hit=0. With L1BUF_ZERO_SUPPRESS_EN defined -> no record, out_valid stays 0.
